bcd_field_overlay: RTL and testbench
====================================

Name: bcd_field_overlay

Overview:
Parametrised VGA text overlay that renders NUM_FIELDS groups of BCD digits (date/time style fields) at a programmable screen origin, with integer glyph scaling. It adds frame-synchronous digit latching, cursor highlight with blink in programming mode, and blanking of invalid BCD codes. It sits between the VGA sync generator and the RGB mixer and drives an external synchronous font ROM.

Parameters:
NUM_FIELDS, 3, number of displayed fields (1..8)
DIGITS, 2, BCD digits per field (1..4)
X0, 272, left pixel of field 0 digit 0
Y0, 127, top pixel of the digit row
FIELD_PITCH, 48, horizontal pixel distance between field starts; must be >= DIGITS*8*2^SCALE_LOG2
SCALE_LOG2, 1, glyph magnification (8x16 glyph -> 16x32 at 1)
CURSOR_BASE, 3, cursor value that selects field 0; field k is selected by CURSOR_BASE+k
BLINK_LOG2, 4, blink half-period = 2^BLINK_LOG2 frames
FG_COLOR, 12'hFFF, normal glyph colour
CUR_COLOR, 12'hF00, highlighted glyph colour

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
video_on  in  1  active video from sync generator
pixel_x  in  10  current pixel column
pixel_y  in  10  current pixel row
frame_tick  in  1  one-cycle pulse at start of vertical blank
digits  in  NUM_FIELDS*DIGITS*4  packed BCD, field 0 digit 0 (most significant) in MSBs
prog_on  in  1  programming mode enable
cursor  in  4  field currently being edited
rom_addr  out  8  {bcd_code[3:0], glyph_row[3:0]} to font ROM
rom_data  in  8  glyph row, valid one cycle after rom_addr; bit 7 = leftmost pixel
rgb_text  out  12  overlay colour, 0 where no glyph pixel
text_on  out  1  high where rgb_text is a lit glyph pixel

Behaviour:
- Reset: rgb_text=0, text_on=0, rom_addr=0, shadow digit register=0, blink counter=0, pipeline valid bits=0.
- Digit latching: shadow register loads digits only on frame_tick; mid-frame changes to digits are invisible until next frame (no tearing). frame_tick and reset together: reset wins.
- Blink: counter of BLINK_LOG2+1 bits increments on each frame_tick, wraps modulo 2^(BLINK_LOG2+1); blink_phase = MSB.
- Hit decode (stage 0, combinational on inputs, registered): cell width W=8<<SCALE_LOG2, height H=16<<SCALE_LOG2. Field f spans X0+f*FIELD_PITCH .. +DIGITS*W-1; rows Y0 .. Y0+H-1. Gap pixels between fields are misses. Stage-0 registers: hit, field index, digit code, glyph_row=(pixel_y-Y0)>>SCALE_LOG2, glyph_col=((pixel_x-X0-f*FIELD_PITCH)>>SCALE_LOG2) mod 8, video_on.
- rom_addr driven from stage-0 registers; rom_data arrives in stage 1 with all stage-0 fields delayed one cycle.
- Stage 2 (output register): bit = rom_data[7-glyph_col]. lit = hit & video_on & bit & (code<=9). Codes 10..15 render blank.
- Colour: if prog_on and cursor==CURSOR_BASE+field: CUR_COLOR when blink_phase=0, lit pixels suppressed (rgb 0, text_on 0) when blink_phase=1; otherwise FG_COLOR. Cursor matching no field: no highlight. prog_on/cursor sampled in stage 0 and piped with pixel data.
- Latency: 3 clk from pixel_x/pixel_y/video_on to rgb_text/text_on; fixed, independent of hit; downstream compensates sync by 3.
- rgb_text=0 and text_on=0 whenever not lit (including video_on=0).
- Reset mid-frame: outputs 0 from the cycle after reset asserted; digits show 0 until first frame_tick after release.

Decomposition:
- Shared package: glyph width/height constants (8,16), colour constants (black, white, red), rom_addr field layout, max field/digit limits.
- One sub-module natural: bcd_field_hit — combinational position decoder returning hit, field index, digit index, glyph row/col for given pixel_x/pixel_y; instantiated once in stage 0.

Test Plan:
- Reset then frame_tick with digits=24'h170517, scan row y=127 -> rom_addr at x=272 is {4'h1,4'h0}; lit pixels on x=272..303 are 12'hFFF, 3 cycles after pixel input.
- Change digits to 24'h999999 mid-frame -> display unchanged until next frame_tick, then rom_addr codes = 9.
- prog_on=1, cursor=4, blink_phase=0 -> field 1 (x=320..351) lit pixels 12'hF00, fields 0 and 2 12'hFFF; after 16 frame_ticks field 1 blank (rgb 0, text_on 0).
- digits field 2 = 8'hAF -> x=368..399 always rgb 0; gap x=304..319 rgb 0 for any digits.
- video_on=0 inside a field region -> rgb_text=0, text_on=0.
- SCALE_LOG2=0, NUM_FIELDS=4, DIGITS=1 build: glyph 8x16, hit only x in [X0+k*FIELD_PITCH, +7]; reset asserted mid-line -> rgb_text=0 next cycle, digits 0 until frame_tick.

Source files
------------

// File: rtl/bcd_field_overlay_pkg.sv
// Shared types and constants for the BCD field text overlay.
// Holds glyph geometry, colours, font ROM address layout and pipeline bundle.
package bcd_field_overlay_pkg;

    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 16;

    localparam int MAX_FIELDS  = 8;
    localparam int MAX_DIGITS  = 4;
    localparam int FIELD_IDX_W = 3;
    localparam int DIGIT_IDX_W = 2;

    localparam int ROM_CODE_W  = 4;
    localparam int ROM_ROW_W   = 4;
    localparam int ROM_ADDR_W  = ROM_CODE_W + ROM_ROW_W;

    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_WHITE = 12'hFFF;
    localparam logic [11:0] COLOR_RED   = 12'hF00;

    // Per-pixel bundle carried from the decode stage to the output stage.
    typedef struct packed {
        logic                   hit;
        logic [FIELD_IDX_W-1:0] field;
        logic [ROM_CODE_W-1:0]  code;
        logic [2:0]             col;
        logic                   vid;
        logic                   prog;
        logic [3:0]             cursor;
    } pix_t;

    function automatic logic [ROM_ADDR_W-1:0] rom_addr_pack(
        input logic [ROM_CODE_W-1:0] code,
        input logic [ROM_ROW_W-1:0]  row
    );
        return {code, row};
    endfunction

    function automatic logic bcd_valid(input logic [ROM_CODE_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_field_overlay_hit.sv
// Combinational screen-position decoder for the BCD field overlay.
// Ports: pixel_x_i/pixel_y_i in; hit_o, field_o, digit_o, glyph_row_o, glyph_col_o out.
module bcd_field_overlay_hit
    import bcd_field_overlay_pkg::*;
#(
    parameter int NUM_FIELDS  = 3,
    parameter int DIGITS      = 2,
    parameter int X0          = 272,
    parameter int Y0          = 127,
    parameter int FIELD_PITCH = 48,
    parameter int SCALE_LOG2  = 1
) (
    input  logic [9:0]             pixel_x_i,
    input  logic [9:0]             pixel_y_i,
    output logic                   hit_o,
    output logic [FIELD_IDX_W-1:0] field_o,
    output logic [DIGIT_IDX_W-1:0] digit_o,
    output logic [ROM_ROW_W-1:0]   glyph_row_o,
    output logic [2:0]             glyph_col_o
);

    localparam int CELL_W = GLYPH_W << SCALE_LOG2;
    localparam int CELL_H = GLYPH_H << SCALE_LOG2;
    localparam int SPAN_W = DIGITS * CELL_W;

    // 12-bit differences: bit 11 set means the pixel lies left of / above origin.
    logic [11:0] dx;
    logic [11:0] dy;
    logic [11:0] off;
    logic        row_ok;

    always_comb begin
        hit_o       = 1'b0;
        field_o     = '0;
        digit_o     = '0;
        glyph_row_o = '0;
        glyph_col_o = '0;
        off         = '0;
        dx          = {2'b00, pixel_x_i} - 12'(X0);
        dy          = {2'b00, pixel_y_i} - 12'(Y0);
        row_ok      = !dy[11] && (dy < 12'(CELL_H));
        if (row_ok && !dx[11]) begin
            for (int f = 0; f < NUM_FIELDS; f++) begin
                if (dx >= 12'(f * FIELD_PITCH) &&
                    dx <  12'(f * FIELD_PITCH + SPAN_W)) begin
                    hit_o   = 1'b1;
                    field_o = FIELD_IDX_W'(f);
                    off     = dx - 12'(f * FIELD_PITCH);
                end
            end
        end
        if (hit_o) begin
            digit_o     = DIGIT_IDX_W'(off >> (3 + SCALE_LOG2));
            glyph_col_o = 3'(off >> SCALE_LOG2);
            glyph_row_o = ROM_ROW_W'(dy >> SCALE_LOG2);
        end
    end

endmodule

// File: rtl/bcd_field_overlay.sv
// VGA text overlay drawing NUM_FIELDS groups of BCD digits with scaling and cursor blink.
// Ports: clk, reset, video_on, pixel_x/y, frame_tick, digits, prog_on, cursor,
//        rom_addr/rom_data (sync font ROM), rgb_text, text_on. Latency 3 clk.
module bcd_field_overlay
    import bcd_field_overlay_pkg::*;
#(
    parameter int          NUM_FIELDS  = 3,
    parameter int          DIGITS      = 2,
    parameter int          X0          = 272,
    parameter int          Y0          = 127,
    parameter int          FIELD_PITCH = 48,
    parameter int          SCALE_LOG2  = 1,
    parameter int          CURSOR_BASE = 3,
    parameter int          BLINK_LOG2  = 4,
    parameter logic [11:0] FG_COLOR    = COLOR_WHITE,
    parameter logic [11:0] CUR_COLOR   = COLOR_RED
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           video_on,
    input  logic [9:0]                     pixel_x,
    input  logic [9:0]                     pixel_y,
    input  logic                           frame_tick,
    input  logic [NUM_FIELDS*DIGITS*4-1:0] digits,
    input  logic                           prog_on,
    input  logic [3:0]                     cursor,
    output logic [ROM_ADDR_W-1:0]          rom_addr,
    input  logic [7:0]                     rom_data,
    output logic [11:0]                    rgb_text,
    output logic                           text_on
);

    localparam int NUM_DIGITS = NUM_FIELDS * DIGITS;
    localparam int BLINK_W    = BLINK_LOG2 + 1;

    logic [NUM_DIGITS*4-1:0] shadow_q, shadow_d;
    logic [BLINK_W-1:0]      blink_q, blink_d;

    logic                   hit;
    logic [FIELD_IDX_W-1:0] hit_field;
    logic [DIGIT_IDX_W-1:0] hit_digit;
    logic [ROM_ROW_W-1:0]   hit_row;
    logic [2:0]             hit_col;
    logic [ROM_CODE_W-1:0]  sel_code;

    pix_t                 s0_d, s0_q, s1_q;
    logic [ROM_ROW_W-1:0] s0_row_q;

    logic        pix_bit;
    logic        lit;
    logic        cur_sel;
    logic [11:0] rgb_d, rgb_q;
    logic        on_d, on_q;

    bcd_field_overlay_hit #(
        .NUM_FIELDS  (NUM_FIELDS),
        .DIGITS      (DIGITS),
        .X0          (X0),
        .Y0          (Y0),
        .FIELD_PITCH (FIELD_PITCH),
        .SCALE_LOG2  (SCALE_LOG2)
    ) u_hit (
        .pixel_x_i   (pixel_x),
        .pixel_y_i   (pixel_y),
        .hit_o       (hit),
        .field_o     (hit_field),
        .digit_o     (hit_digit),
        .glyph_row_o (hit_row),
        .glyph_col_o (hit_col)
    );

    // Digits are only sampled at frame boundaries so a frame never tears.
    always_comb begin
        shadow_d = shadow_q;
        blink_d  = blink_q;
        if (frame_tick) begin
            shadow_d = digits;
            blink_d  = blink_q + BLINK_W'(1);
        end
    end

    // Field 0 digit 0 sits in the MSBs of the shadow word.
    always_comb begin
        sel_code = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (hit && (int'(hit_field) * DIGITS + int'(hit_digit) == i))
                sel_code = shadow_q[(NUM_DIGITS-1-i)*4 +: 4];
        end
    end

    always_comb begin
        s0_d        = '0;
        s0_d.hit    = hit;
        s0_d.field  = hit_field;
        s0_d.code   = sel_code;
        s0_d.col    = hit_col;
        s0_d.vid    = video_on;
        s0_d.prog   = prog_on;
        s0_d.cursor = cursor;
    end

    assign rom_addr = rom_addr_pack(s0_q.code, s0_row_q);

    // Blink MSB set: highlighted field disappears for that half-period.
    always_comb begin
        pix_bit = rom_data[3'd7 - s1_q.col];
        lit     = s1_q.hit & s1_q.vid & pix_bit & bcd_valid(s1_q.code);
        cur_sel = s1_q.prog &&
                  (int'(s1_q.cursor) == CURSOR_BASE + int'(s1_q.field));
        rgb_d   = COLOR_BLACK;
        on_d    = 1'b0;
        if (lit) begin
            if (!cur_sel) begin
                rgb_d = FG_COLOR;
                on_d  = 1'b1;
            end else if (!blink_q[BLINK_W-1]) begin
                rgb_d = CUR_COLOR;
                on_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            blink_q  <= '0;
            s0_q     <= '0;
            s0_row_q <= '0;
            s1_q     <= '0;
            rgb_q    <= COLOR_BLACK;
            on_q     <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            blink_q  <= blink_d;
            s0_q     <= s0_d;
            s0_row_q <= hit_row;
            s1_q     <= s0_q;
            rgb_q    <= rgb_d;
            on_q     <= on_d;
        end
    end

    assign rgb_text = rgb_q;
    assign text_on  = on_q;

endmodule

// File: tb/tb_bcd_field_overlay.sv
// Bench for bcd_field_overlay: default build plus a 4x1-digit unscaled build.
// Font model: even glyph rows 8'hF0, odd rows 8'h0F, one cycle after address.
module tb_bcd_field_overlay;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_tick;
    logic [23:0] digits;
    logic [15:0] digits2;
    logic        prog_on;
    logic [3:0]  cursor;
    logic [7:0]  rom_addr, rom_addr2;
    logic [7:0]  rom_data = 8'h00;
    logic [7:0]  rom_data2 = 8'h00;
    logic [11:0] rgb_text, rgb_text2;
    logic        text_on, text_on2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= rom_addr[0]  ? 8'h0F : 8'hF0;
        rom_data2 <= rom_addr2[0] ? 8'h0F : 8'hF0;
    end

    bcd_field_overlay dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick),
        .digits     (digits),
        .prog_on    (prog_on),
        .cursor     (cursor),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rgb_text   (rgb_text),
        .text_on    (text_on)
    );

    bcd_field_overlay #(
        .NUM_FIELDS  (4),
        .DIGITS      (1),
        .X0          (100),
        .Y0          (50),
        .FIELD_PITCH (20),
        .SCALE_LOG2  (0)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick),
        .digits     (digits2),
        .prog_on    (prog_on),
        .cursor     (cursor),
        .rom_addr   (rom_addr2),
        .rom_data   (rom_data2),
        .rgb_text   (rgb_text2),
        .text_on    (text_on2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input logic v);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = v;
    endtask

    task automatic px(input int x, input int y, input logic v);
        drive(x, y, v);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic px_addr(input int x, input int y);
        drive(x, y, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
        end
    endtask

    task automatic exp_px(input string tag, input logic [11:0] rgb);
        check_eq({tag, ".rgb"}, 32'(rgb_text), 32'(rgb));
        check_eq({tag, ".on"}, 32'(text_on), 32'(rgb != 12'h000));
    endtask

    task automatic exp_px2(input string tag, input logic [11:0] rgb);
        check_eq({tag, ".rgb"}, 32'(rgb_text2), 32'(rgb));
        check_eq({tag, ".on"}, 32'(text_on2), 32'(rgb != 12'h000));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        digits     = 24'h170517;
        digits2    = 16'h1234;
        prog_on    = 1'b0;
        cursor     = 4'd0;
        drive(272, 127, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        exp_px("reset", 12'h000);
        check_eq("reset.addr", 32'(rom_addr), 32'h00);
        reset = 1'b0;

        px_addr(272, 127);
        check_eq("pretick.addr", 32'(rom_addr), 32'h00);
        tick(1);
        px_addr(272, 127);
        check_eq("f0d0.addr", 32'(rom_addr), 32'h10);
        px_addr(288, 127);
        check_eq("f0d1.addr", 32'(rom_addr), 32'h70);
        px_addr(320, 129);
        check_eq("f1d0.addr", 32'(rom_addr), 32'h01);
        px_addr(384, 158);
        check_eq("f2d1.addr", 32'(rom_addr), 32'h7F);

        px(271, 127, 1'b1);
        exp_px("left_miss", 12'h000);
        drive(272, 127, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("lat2.on", 32'(text_on), 32'h0);
        @(posedge clk);
        #1;
        exp_px("lat3", 12'hFFF);

        px(279, 127, 1'b1);
        exp_px("x279", 12'hFFF);
        px(280, 127, 1'b1);
        exp_px("x280", 12'h000);
        px(288, 127, 1'b1);
        exp_px("x288", 12'hFFF);
        px(303, 127, 1'b1);
        exp_px("x303", 12'h000);
        px(280, 129, 1'b1);
        exp_px("row1.x280", 12'hFFF);
        px(272, 129, 1'b1);
        exp_px("row1.x272", 12'h000);
        px(280, 158, 1'b1);
        exp_px("row15", 12'hFFF);
        px(280, 159, 1'b1);
        exp_px("below", 12'h000);
        px(304, 127, 1'b1);
        exp_px("gap304", 12'h000);
        px(310, 127, 1'b1);
        exp_px("gap310", 12'h000);

        digits = 24'h999999;
        px_addr(272, 127);
        check_eq("midframe.addr", 32'(rom_addr), 32'h10);
        tick(1);
        px_addr(272, 127);
        check_eq("newframe.addr", 32'(rom_addr), 32'h90);

        digits = 24'h1705AF;
        tick(1);
        px_addr(368, 127);
        check_eq("codeA.addr", 32'(rom_addr), 32'hA0);
        px(368, 127, 1'b1);
        exp_px("codeA", 12'h000);
        px(384, 127, 1'b1);
        exp_px("codeF", 12'h000);
        px(320, 127, 1'b1);
        exp_px("code0", 12'hFFF);

        digits = 24'h170517;
        tick(1);
        prog_on = 1'b1;
        cursor  = 4'd4;
        px(320, 127, 1'b1);
        exp_px("cur4.f1", 12'hF00);
        px(272, 127, 1'b1);
        exp_px("cur4.f0", 12'hFFF);
        px(368, 127, 1'b1);
        exp_px("cur4.f2", 12'hFFF);
        cursor = 4'd3;
        px(272, 127, 1'b1);
        exp_px("cur3.f0", 12'hF00);
        cursor = 4'd9;
        px(272, 127, 1'b1);
        exp_px("cur9.f0", 12'hFFF);
        prog_on = 1'b0;
        cursor  = 4'd4;
        px(320, 127, 1'b1);
        exp_px("noprog.f1", 12'hFFF);

        prog_on = 1'b1;
        tick(16);
        px(320, 127, 1'b1);
        exp_px("blink.f1", 12'h000);
        px(272, 127, 1'b1);
        exp_px("blink.f0", 12'hFFF);
        tick(12);
        px(320, 127, 1'b1);
        exp_px("wrap.f1", 12'hF00);
        prog_on = 1'b0;

        px(272, 127, 1'b0);
        exp_px("novideo", 12'h000);

        px_addr(100, 50);
        check_eq("b2.f0.addr", 32'(rom_addr2), 32'h10);
        px_addr(140, 65);
        check_eq("b2.f2.addr", 32'(rom_addr2), 32'h3F);
        px(103, 50, 1'b1);
        exp_px2("b2.x103", 12'hFFF);
        px(107, 50, 1'b1);
        exp_px2("b2.x107", 12'h000);
        px(108, 50, 1'b1);
        exp_px2("b2.x108", 12'h000);
        px(124, 51, 1'b1);
        exp_px2("b2.x124", 12'hFFF);
        px(120, 51, 1'b1);
        exp_px2("b2.x120", 12'h000);
        px(100, 66, 1'b1);
        exp_px2("b2.y66", 12'h000);

        px(272, 127, 1'b1);
        exp_px("prerst", 12'hFFF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_px("midrst", 12'h000);
        exp_px2("midrst2", 12'h000);
        check_eq("midrst.addr", 32'(rom_addr), 32'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        px_addr(272, 127);
        check_eq("postrst.addr", 32'(rom_addr), 32'h00);
        px_addr(100, 50);
        check_eq("postrst2.addr", 32'(rom_addr2), 32'h00);
        px(272, 127, 1'b1);
        exp_px("postrst.d0", 12'hFFF);
        tick(1);
        px_addr(272, 127);
        check_eq("rsttick.addr", 32'(rom_addr), 32'h10);
        prog_on = 1'b1;
        cursor  = 4'd4;
        px(320, 127, 1'b1);
        exp_px("rstblink.f1", 12'hF00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
